// File: rtl/ras_ctrl_if.sv
// Front-end handshake between the branch-prediction unit and the
// return-address-stack controller. The master side issues push/pop
// requests; the slave side (ras_ctrl) reports stack status.
interface ras_ctrl_if #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 36
);
  localparam int CW = $clog2(DEPTH + 3);

  logic             push_i;
  logic             pop_i;
  logic [WIDTH-1:0] push_addr_i;
  logic             ready_o;
  logic [WIDTH-1:0] tos_o;
  logic             tos_valid_o;
  logic [CW-1:0]    count_o;
  logic             full_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output push_i, pop_i, push_addr_i,
    input  ready_o, tos_o, tos_valid_o, count_o, full_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, pop_i, push_addr_i,
    output ready_o, tos_o, tos_valid_o, count_o, full_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack controller. The top two entries live in registers
// (TOS/NOS); deeper entries spill to an external dual-port BRAM used as a
// circular buffer addressed by wp. Overflow overwrites the oldest entry.
module ras_ctrl #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 36,
  localparam int ADDR  = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 3)
) (
  input  logic             clk,
  input  logic             rst_n,
  ras_ctrl_if.slave        fe,
  output logic             mem_wea_o,
  output logic [ADDR-1:0]  mem_waddra_o,
  output logic [WIDTH-1:0] mem_wia_o,
  output logic             mem_reb_o,
  output logic [ADDR-1:0]  mem_raddrb_o,
  input  logic [WIDTH-1:0] mem_dob_i
);

  localparam logic [CW-1:0] CAP = CW'(DEPTH + 2);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ADDR-1:0]  wp_q, wp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wea, reb;

  // Next-state, stack update and BRAM strobe decode for the current request.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    count_d = count_q;
    wp_d    = wp_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    wea     = 1'b0;
    reb     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fe.push_i && fe.pop_i) begin
          // Replace the top in place; depth is unchanged unless empty.
          tos_d = fe.push_addr_i;
          if (count_q == '0) count_d = CW'(1);
        end else if (fe.push_i) begin
          tos_d = fe.push_addr_i;
          if (count_q != '0) nos_d = tos_q;
          if (count_q >= CW'(2)) begin
            wea  = 1'b1;
            wp_d = wp_q + 1'b1;
          end
          if (count_q == CAP) ovf_d = 1'b1;
          else                count_d = count_q + 1'b1;
        end else if (fe.pop_i) begin
          if (count_q == '0) begin
            udf_d = 1'b1;
          end else if (count_q == CW'(1)) begin
            count_d = '0;
          end else begin
            tos_d   = nos_q;
            count_d = count_q - 1'b1;
            if (count_q >= CW'(3)) begin
              // NOS is refilled from the BRAM on the following cycle.
              reb     = 1'b1;
              wp_d    = wp_q - 1'b1;
              state_d = REFILL;
            end
          end
        end
      end
      REFILL: begin
        nos_d   = mem_dob_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values. The BRAM itself is never cleared:
  // count alone defines emptiness, so stale BRAM data is unreachable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tos_q   <= '0;
      nos_q   <= '0;
      count_q <= '0;
      wp_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      count_q <= count_d;
      wp_q    <= wp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // BRAM strobes are suppressed while reset is held; addresses and data
  // idle at zero whenever their strobe is low.
  assign mem_wea_o    = wea & rst_n;
  assign mem_waddra_o = mem_wea_o ? wp_q : '0;
  assign mem_wia_o    = mem_wea_o ? nos_q : '0;
  assign mem_reb_o    = reb & rst_n;
  assign mem_raddrb_o = mem_reb_o ? wp_q - 1'b1 : '0;

  assign fe.ready_o     = (state_q == IDLE);
  assign fe.tos_o       = tos_q;
  assign fe.tos_valid_o = (count_q != '0);
  assign fe.count_o     = count_q;
  assign fe.full_o      = (count_q == CAP);
  assign fe.overflow_o  = ovf_q;
  assign fe.underflow_o = udf_q;

endmodule
